multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences the single shared ALU
//  (via alu_op/alu_src into the ALU-control stage), PC, IR, register file and

---
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/multicycle_ctrl.sv | 129 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multi-cycle FSM and the datapath
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_src;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic             iord;
   logic             reg_write;
   logic             mem_to_reg;
   logic             alu_src;
   logic [1:0]       alu_op;
   logic             illegal;
   logic             halted;
   logic [CNT_W-1:0] retired;
   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
             mem_to_reg, alu_src, alu_op, illegal, halted, retired
   );
   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
             mem_to_reg, alu_src, alu_op, illegal, halted, retired
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM sequencing PC, IR, ALU, register file and memory
module multicycle_ctrl #(
   parameter int CNT_W        = 32,
   parameter bit ILLEGAL_HALT = 1'b0
) (
   input logic               clk,
   input logic               reset,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR,
      WB_ALU, WB_MEM, BRANCH, ILLEGAL, HALT
   } state_t;
   state_t           st, nxt;
   logic             is_store;
   logic [CNT_W-1:0] cnt;
   logic             pc_write, pc_src, ir_write, mem_read, mem_write, iord;
   logic             reg_write, mem_to_reg, alu_src, illegal, halted, retire;
   logic [1:0]       alu_op;
   // state register; load/store kind is captured in DECODE since opcode is not looked at again
   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= FETCH;
         is_store <= 1'b0;
         cnt      <= '0;
      end else begin
         st <= nxt;
         if (st == DECODE) is_store <= bus.opcode == 7'b0100011;
         if (retire) cnt <= cnt + CNT_W'(1);
      end
   end
   // next state plus Moore control decode, with mem_ready/zero qualifying the handshake states
   always_comb begin
      nxt        = st;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      halted     = 1'b0;
      retire     = 1'b0;
      case (st)
         FETCH: begin
            mem_read = 1'b1;
            ir_write = bus.mem_ready;
            pc_write = bus.mem_ready;
            nxt      = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            case (bus.opcode)
               7'b0110011:             nxt = EXEC_R;
               7'b0010011:             nxt = EXEC_I;
               7'b0000011, 7'b0100011: nxt = ADDR;
               7'b1100011:             nxt = BRANCH;
               default:                nxt = ILLEGAL;
            endcase
         end
         EXEC_R: begin
            alu_op = 2'b10;
            nxt    = WB_ALU;
         end
         EXEC_I: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            nxt     = WB_ALU;
         end
         WB_ALU: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            nxt       = FETCH;
         end
         ADDR: begin
            alu_src = 1'b1;
            nxt     = is_store ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            alu_src  = 1'b1;
            nxt      = bus.mem_ready ? WB_MEM : MEM_RD;
         end
         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            nxt        = FETCH;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            alu_src   = 1'b1;
            retire    = bus.mem_ready;
            nxt       = bus.mem_ready ? FETCH : MEM_WR;
         end
         BRANCH: begin
            alu_op   = 2'b01;
            pc_src   = 1'b1;
            pc_write = bus.zero;
            retire   = 1'b1;
            nxt      = FETCH;
         end
         ILLEGAL: begin
            illegal = 1'b1;
            nxt     = ILLEGAL_HALT ? HALT : FETCH;
         end
         HALT:    halted = 1'b1;
         default: nxt = FETCH;
      endcase
   end
   assign bus.pc_write   = !reset && pc_write;
   assign bus.pc_src     = !reset && pc_src;
   assign bus.ir_write   = !reset && ir_write;
   assign bus.mem_read   = !reset && mem_read;
   assign bus.mem_write  = !reset && mem_write;
   assign bus.iord       = !reset && iord;
   assign bus.reg_write  = !reset && reg_write;
   assign bus.mem_to_reg = !reset && mem_to_reg;
   assign bus.alu_src    = !reset && alu_src;
   assign bus.alu_op     = reset ? 2'b00 : alu_op;
   assign bus.illegal    = !reset && illegal;
   assign bus.halted     = !reset && halted;
   assign bus.retired    = reset ? '0 : cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed table-driven check of the multi-cycle control FSM
module tb_multicycle_ctrl;
   localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011, BEQ = 7'b1100011, BAD = 7'b1111111;
   // control vector order: pc_write pc_src ir_write | mem_read mem_write iord | reg_write mem_to_reg | alu_src | alu_op | illegal halted
   localparam logic [12:0] NONE = 13'b000_000_00_0_00_00;
   localparam logic [12:0] F_WT = 13'b000_100_00_0_00_00;
   localparam logic [12:0] F_RD = 13'b101_100_00_0_00_00;
   localparam logic [12:0] EXR  = 13'b000_000_00_0_10_00;
   localparam logic [12:0] EXI  = 13'b000_000_00_1_10_00;
   localparam logic [12:0] WBA  = 13'b000_000_10_0_00_00;
   localparam logic [12:0] ADR  = 13'b000_000_00_1_00_00;
   localparam logic [12:0] MRD  = 13'b000_101_00_1_00_00;
   localparam logic [12:0] MWR  = 13'b000_011_00_1_00_00;
   localparam logic [12:0] WBM  = 13'b000_000_11_0_00_00;
   localparam logic [12:0] BRT  = 13'b110_000_00_0_01_00;
   localparam logic [12:0] BRN  = 13'b010_000_00_0_01_00;
   localparam logic [12:0] ILL  = 13'b000_000_00_0_00_10;
   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        z;
      logic        rdy;
      logic [12:0] ctl;
      logic [31:0] ret;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;
   vec_t       tv[$];
   multicycle_ctrl_if #(.CNT_W(32)) i0 ();
   multicycle_ctrl_if #(.CNT_W(4))  i1 ();
   assign i0.opcode = opcode;
   assign i0.zero = zero;
   assign i0.mem_ready = mem_ready;
   assign i1.opcode = opcode;
   assign i1.zero = zero;
   assign i1.mem_ready = mem_ready;
   multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) d0 (.clk(clk), .reset(reset), .bus(i0));
   multicycle_ctrl #(.CNT_W(4),  .ILLEGAL_HALT(1'b1)) d1 (.clk(clk), .reset(reset), .bus(i1));
   wire logic [12:0] ctl0 = {i0.pc_write, i0.pc_src, i0.ir_write, i0.mem_read, i0.mem_write, i0.iord,
                             i0.reg_write, i0.mem_to_reg, i0.alu_src, i0.alu_op, i0.illegal, i0.halted};
   always #5 clk = ~clk;
   task automatic drive(input logic r, input logic [6:0] o, input logic z, input logic rd);
      @(negedge clk);
      reset = r;
      opcode = o;
      zero = z;
      mem_ready = rd;
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic row(input logic r, input logic [6:0] o, input logic z, input logic rd,
                      input logic [12:0] c, input logic [31:0] rt);
      tv.push_back('{r, o, z, rd, c, rt});
   endtask
   initial begin
      row(1, 0,    0, 1, NONE, 0);
      row(1, 0,    0, 1, NONE, 0);
      row(0, 0,    0, 1, F_RD, 0);
      row(0, ADD,  0, 1, NONE, 0);
      row(0, 0,    0, 1, EXR,  0);
      row(0, 0,    0, 1, WBA,  0);
      row(0, 0,    0, 0, F_WT, 1);
      row(0, 0,    0, 1, F_RD, 1);
      row(0, ADDI, 0, 1, NONE, 1);
      row(0, 0,    0, 1, EXI,  1);
      row(0, 0,    0, 1, WBA,  1);
      row(0, 0,    0, 1, F_RD, 2);
      row(0, LW,   0, 1, NONE, 2);
      row(0, 0,    0, 1, ADR,  2);
      row(0, 0,    0, 0, MRD,  2);
      row(0, 0,    0, 0, MRD,  2);
      row(0, 0,    0, 0, MRD,  2);
      row(0, 0,    0, 1, MRD,  2);
      row(0, 0,    0, 1, WBM,  2);
      row(0, 0,    0, 1, F_RD, 3);
      row(0, SW,   0, 1, NONE, 3);
      row(0, LW,   0, 1, ADR,  3);
      row(0, 0,    0, 0, MWR,  3);
      row(0, 0,    0, 1, MWR,  3);
      row(0, 0,    0, 1, F_RD, 4);
      row(0, BEQ,  0, 1, NONE, 4);
      row(0, 0,    1, 1, BRT,  4);
      row(0, 0,    0, 1, F_RD, 5);
      row(0, BEQ,  0, 1, NONE, 5);
      row(0, 0,    0, 1, BRN,  5);
      row(0, 0,    0, 1, F_RD, 6);
      row(0, BAD,  0, 1, NONE, 6);
      row(0, 0,    0, 1, ILL,  6);
      row(0, 0,    0, 1, F_RD, 6);
      row(0, SW,   0, 1, NONE, 6);
      row(0, 0,    0, 1, ADR,  6);
      row(0, 0,    0, 0, MWR,  6);
      row(1, 0,    0, 0, NONE, 0);
      row(0, 0,    0, 0, F_WT, 0);
      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].op, tv[i].z, tv[i].rdy);
         chk($sformatf("row%0d ctl", i), 32'(ctl0), 32'(tv[i].ctl));
         chk($sformatf("row%0d retired", i), i0.retired, tv[i].ret);
      end
      drive(1, 0, 0, 1);
      for (int k = 0; k < 16; k++) begin
         drive(0, 0, 0, 1);
         chk($sformatf("wrap add%0d retired", k), 32'(i1.retired), 32'(k));
         drive(0, ADD, 0, 1);
         drive(0, 0, 0, 1);
         drive(0, 0, 0, 1);
      end
      drive(0, 0, 0, 1);
      chk("wrap retired 15->0", 32'(i1.retired), 0);
      chk("wide retired 16", i0.retired, 16);
      drive(0, BAD, 0, 1);
      drive(0, 0, 0, 1);
      chk("halt-cfg illegal pulse", 32'(i1.illegal), 1);
      chk("skip-cfg illegal pulse", 32'(i0.illegal), 1);
      drive(0, 0, 0, 1);
      chk("halt-cfg halted", 32'(i1.halted), 1);
      chk("halt-cfg illegal one cycle", 32'(i1.illegal), 0);
      chk("skip-cfg refetch", 32'(ctl0), 32'(F_RD));
      for (int k = 0; k < 3; k++) begin
         drive(0, ADD, 1, 1);
         chk($sformatf("halt stays %0d", k), 32'(i1.halted), 1);
         chk($sformatf("halt no mem_read %0d", k), 32'(i1.mem_read), 0);
      end
      chk("halt retired unchanged", 32'(i1.retired), 0);
      drive(1, 0, 0, 1);
      chk("halt forced off in reset", 32'(i1.halted), 0);
      drive(0, 0, 0, 0);
      chk("halt exit by reset", 32'(i1.halted), 0);
      chk("halt exit fetch", 32'(i1.mem_read), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
